// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: walks each instruction through fetch/decode/execute/memory/write-back,
// handshakes with a variable-latency memory, flags illegal opcodes and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        aluSrc,
    output logic [2:0]  toAlu,
    output logic        regWr,
    output logic        regDst,
    output logic        memToReg,
    output logic        li,
    output logic        link,
    output logic        illegal,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6,
        ERR    = 3'd7
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LI    = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    stateT       curState;
    logic [5:0]  opReg;
    logic [5:0]  functReg;
    logic        illegalFlag;
    logic [31:0] retiredCount;
    logic        retire;

    logic isRtype, isJr, isLw, isSw, isLi, isBeq, isBne, isJal, isImm;

    function automatic logic isLegal(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LI, OP_LW, OP_SW: isLegal = 1'b1;
            default:                              isLegal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] aluClassOf(input logic [5:0] o);
        case (o)
            OP_ORI:               aluClassOf = 3'b001;
            OP_ADDI, OP_LW, OP_SW: aluClassOf = 3'b010;
            OP_LI:                aluClassOf = 3'b011;
            OP_ANDI:              aluClassOf = 3'b110;
            OP_SLTI:              aluClassOf = 3'b111;
            default:              aluClassOf = 3'b000;
        endcase
    endfunction

    // Everything past DECODE steers from the latched fields, never the live IR bits.
    assign isRtype = (opReg == OP_RTYPE);
    assign isJr    = isRtype && (functReg == FN_JR);
    assign isLw    = (opReg == OP_LW);
    assign isSw    = (opReg == OP_SW);
    assign isLi    = (opReg == OP_LI);
    assign isBeq   = (opReg == OP_BEQ);
    assign isBne   = (opReg == OP_BNE);
    assign isJal   = (opReg == OP_JAL);
    assign isImm   = (opReg == OP_ADDI) || (opReg == OP_SLTI) || (opReg == OP_ANDI) ||
                     (opReg == OP_ORI)  || isLw || isSw;

    always_ff @(posedge clk) begin
        if (reset) begin
            curState     <= FETCH;
            opReg        <= '0;
            functReg     <= '0;
            illegalFlag  <= 1'b0;
            retiredCount <= '0;
        end else begin
            retiredCount <= retiredCount + {31'd0, retire};
            case (curState)
                FETCH:  if (mem_ready) curState <= DECODE;
                DECODE: begin
                    opReg    <= op;
                    functReg <= funct;
                    if (!isLegal(op)) begin
                        curState    <= ERR;
                        illegalFlag <= 1'b1;
                    end else if (op == OP_BEQ || op == OP_BNE) begin
                        curState <= BRANCH;
                    end else if (op == OP_J || op == OP_JAL) begin
                        curState <= JUMP;
                    end else begin
                        curState <= EXEC;
                    end
                end
                EXEC: begin
                    if (isJr)              curState <= FETCH;
                    else if (isLw || isSw) curState <= MEM;
                    else                   curState <= WB;
                end
                MEM:                if (mem_ready) curState <= isLw ? WB : FETCH;
                WB, BRANCH, JUMP:   curState <= FETCH;
                ERR:                curState <= ERR;
            endcase
        end
    end

    // Reset overrides everything so an aborted instruction never leaves a write enable behind.
    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 2'b00;
        aluSrc   = 1'b0;
        toAlu    = 3'b000;
        regWr    = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        li       = 1'b0;
        link     = 1'b0;
        retire   = 1'b0;
        if (!reset) begin
            case (curState)
                FETCH: begin
                    memRead = 1'b1;
                    if (mem_ready) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                    end
                end
                EXEC: begin
                    toAlu  = aluClassOf(opReg);
                    aluSrc = isImm;
                    if (isJr) begin
                        pcWrite = 1'b1;
                        pcSrc   = 2'b11;
                        retire  = 1'b1;
                    end
                end
                MEM: begin
                    memRead  = isLw;
                    memWrite = isSw;
                    retire   = isSw && mem_ready;
                end
                WB: begin
                    regWr    = 1'b1;
                    regDst   = isRtype;
                    memToReg = isLw;
                    li       = isLi;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    toAlu   = 3'b100;
                    pcWrite = (isBeq && zero) || (isBne && !zero);
                    pcSrc   = 2'b01;
                    retire  = 1'b1;
                end
                JUMP: begin
                    pcWrite = 1'b1;
                    pcSrc   = 2'b10;
                    regWr   = isJal;
                    link    = isJal;
                    retire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_done  = retire;
    assign illegal     = !reset && illegalFlag;
    assign instr_count = reset ? 32'd0 : retiredCount;
    assign state       = reset ? 3'd0 : curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is scored against an
// ISA-level model of cycle counts and per-instruction control activity.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LI   = 6'b010000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        memRead, memWrite, irWrite, pcWrite, aluSrc, regWr, regDst;
    logic        memToReg, li, link, illegal, instr_done;
    logic [1:0]  pcSrc;
    logic [2:0]  toAlu;
    logic [31:0] instr_count;
    logic [2:0]  state;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] expCount;
    logic [2:0]  stTrace[$];

    typedef struct packed {
        longint cycles, rd, wr, irw, pcw, regw, alus, lnk, m2r, liC, rdst, pcs, alu;
    } expT;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite),
        .pcSrc(pcSrc), .aluSrc(aluSrc), .toAlu(toAlu), .regWr(regWr), .regDst(regDst),
        .memToReg(memToReg), .li(li), .link(link), .illegal(illegal),
        .instr_done(instr_done), .instr_count(instr_count), .state(state)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // What one instruction should do in total, from the ISA table and the wait counts alone.
    function automatic expT model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                  input int wf, input int wm);
        expT e;
        e     = '0;
        e.irw = 1;
        e.pcw = 1;
        case (o)
            OP_R:    if (f == FN_JR) begin e.cycles = 3; e.pcw = 2; e.pcs = 3; end
                     else begin e.cycles = 4; e.regw = 1; e.rdst = 1; end
            OP_J:    begin e.cycles = 3; e.pcw = 2; e.pcs = 2; end
            OP_JAL:  begin e.cycles = 3; e.pcw = 2; e.pcs = 2; e.regw = 1; e.lnk = 1; end
            OP_BEQ:  begin e.cycles = 3; e.pcw = z ? 2 : 1; e.pcs = 1; e.alu = 4; end
            OP_BNE:  begin e.cycles = 3; e.pcw = z ? 1 : 2; e.pcs = 1; e.alu = 4; end
            OP_ADDI: begin e.cycles = 4; e.regw = 1; e.alus = 1; e.alu = 2; end
            OP_SLTI: begin e.cycles = 4; e.regw = 1; e.alus = 1; e.alu = 7; end
            OP_ANDI: begin e.cycles = 4; e.regw = 1; e.alus = 1; e.alu = 6; end
            OP_ORI:  begin e.cycles = 4; e.regw = 1; e.alus = 1; e.alu = 1; end
            OP_LI:   begin e.cycles = 4; e.regw = 1; e.liC = 1; e.alu = 3; end
            OP_LW:   begin e.cycles = 5 + wm; e.regw = 1; e.alus = 1; e.m2r = 1; e.alu = 2; end
            OP_SW:   begin e.cycles = 4 + wm; e.alus = 1; e.alu = 2; e.wr = wm + 1; end
            default: ;
        endcase
        e.cycles = e.cycles + wf;
        e.rd     = wf + 1 + ((o == OP_LW) ? wm + 1 : 0);
        return e;
    endfunction

    // Runs one instruction from FETCH: wf fetch waits, wm memory waits, mem_ready/zero random elsewhere.
    task automatic applyStimulus(input string name, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int wf, input int wm);
        expT    e;
        longint rd, wr, irw, pcw, regw, alus, lnk, m2r, liC, rdst, cyc;
        logic [1:0] pcsLast;
        logic [2:0] aluSeen;
        bit     done, isMem;
        e = model(o, f, z, wf, wm);
        isMem = (o == OP_LW) || (o == OP_SW);
        rd = 0; wr = 0; irw = 0; pcw = 0; regw = 0; alus = 0; lnk = 0; m2r = 0; liC = 0; rdst = 0;
        cyc = 0; pcsLast = 2'b00; aluSeen = 3'b000; done = 0;
        op = o; funct = f;
        stTrace.delete();
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (t < wf)                  mem_ready = 1'b0;
            else if (t == wf)            mem_ready = 1'b1;
            else if (isMem && t >= wf + 3) mem_ready = (t >= wf + 3 + wm);
            else                         mem_ready = 1'($urandom);
            zero = (t == wf + 2) ? z : 1'($urandom);
            if (t > wf + 1) begin
                op    = 6'($urandom);
                funct = 6'($urandom);
            end
            #1;
            stTrace.push_back(state);
            if (memRead)  rd++;
            if (memWrite) wr++;
            if (irWrite)  irw++;
            if (pcWrite)  pcw++;
            if (regWr)    regw++;
            if (aluSrc)   alus++;
            if (link)     lnk++;
            if (memToReg) m2r++;
            if (li)       liC++;
            if (regDst)   rdst++;
            if (t == wf + 2) aluSeen = toAlu;
            if (instr_done) begin
                done    = 1;
                cyc     = t + 1;
                pcsLast = pcSrc;
                checkOutput({name, ".countBefore"}, 64'(instr_count), 64'(expCount));
            end
        end
        checkOutput({name, ".retired"},  64'(done), 64'd1);
        checkOutput({name, ".cycles"},   cyc,  e.cycles);
        checkOutput({name, ".memRead"},  rd,   e.rd);
        checkOutput({name, ".memWrite"}, wr,   e.wr);
        checkOutput({name, ".irWrite"},  irw,  e.irw);
        checkOutput({name, ".pcWrite"},  pcw,  e.pcw);
        checkOutput({name, ".regWr"},    regw, e.regw);
        checkOutput({name, ".aluSrc"},   alus, e.alus);
        checkOutput({name, ".link"},     lnk,  e.lnk);
        checkOutput({name, ".memToReg"}, m2r,  e.m2r);
        checkOutput({name, ".li"},       liC,  e.liC);
        checkOutput({name, ".regDst"},   rdst, e.rdst);
        checkOutput({name, ".pcSrc"},    64'(pcsLast), e.pcs);
        checkOutput({name, ".toAlu"},    64'(aluSeen), e.alu);
        expCount = expCount + 32'd1;
        @(posedge clk);
        #1;
        checkOutput({name, ".countAfter"}, 64'(instr_count), 64'(expCount));
        checkOutput({name, ".backToFetch"}, 64'(state), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] legalOps[12];
        longint     addiSeq[4];
        logic [5:0] rop, rfn;
        legalOps = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                     OP_ANDI, OP_ORI, OP_LI, OP_LW, OP_SW};
        addiSeq  = '{0, 1, 2, 4};
        expCount = 32'd0;

        // Reset with mem_ready high: every output must sit at zero.
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = OP_SW; funct = 6'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset.allOutputs",
            64'({memRead, memWrite, irWrite, pcWrite, pcSrc, aluSrc, toAlu, regWr, regDst,
                 memToReg, li, link, illegal, instr_done, instr_count, state}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus("addi", OP_ADDI, 6'd0, 1'b0, 0, 0);
        checkOutput("addi.traceLen", 64'(stTrace.size()), 64'd4);
        for (int i = 0; i < 4 && i < stTrace.size(); i++)
            checkOutput($sformatf("addi.state%0d", i), 64'(stTrace[i]), addiSeq[i]);

        applyStimulus("lwWait2", OP_LW,  6'd0, 1'b0, 0, 2);
        applyStimulus("beqZ1",   OP_BEQ, 6'd0, 1'b1, 0, 0);
        applyStimulus("beqZ0",   OP_BEQ, 6'd0, 1'b0, 0, 0);
        applyStimulus("bneZ0",   OP_BNE, 6'd0, 1'b0, 0, 0);
        applyStimulus("jal",     OP_JAL, 6'd0, 1'b0, 0, 0);
        applyStimulus("jr",      OP_R,   FN_JR, 1'b0, 0, 0);
        applyStimulus("swWait1", OP_SW,  6'd0, 1'b0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            rop = legalOps[$urandom_range(0, 11)];
            rfn = ($urandom_range(0, 2) == 0) ? FN_JR : 6'($urandom);
            applyStimulus($sformatf("rand%0d", n), rop, rfn, 1'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset lands on the MEM cycle of a store that memory is ready to accept.
        op = OP_SW; funct = 6'd0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            mem_ready = (t == 0);
            #1;
        end
        checkOutput("swAbort.inExec", 64'(state), 64'd2);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        checkOutput("swAbort.memWrite", 64'(memWrite), 64'd0);
        checkOutput("swAbort.retire", 64'(instr_done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
        expCount = 32'd0;
        @(negedge clk);
        #1;
        checkOutput("swAbort.count", 64'(instr_count), 64'd0);
        checkOutput("swAbort.state", 64'(state), 64'd0);
        checkOutput("swAbort.fetchReq", 64'(memRead), 64'd1);

        // Counter wrap: preload all-ones while parked in FETCH, then retire one ori.
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.retiredCount = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ready = 1'b0;
        release dut.retiredCount;
        #1;
        checkOutput("wrap.preload", 64'(instr_count), 64'hFFFF_FFFF);
        expCount = 32'hFFFF_FFFF;
        applyStimulus("wrap", OP_ORI, 6'd0, 1'b0, 0, 0);
        checkOutput("wrap.zero", 64'(instr_count), 64'd0);

        // Illegal opcode: ERR holds with no enables until reset.
        op = 6'b111111; funct = 6'd0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            mem_ready = (t == 0) ? 1'b1 : 1'($urandom);
            zero = 1'($urandom);
            #1;
            if (t >= 2) begin
                checkOutput($sformatf("err.state%0d", t), 64'(state), 64'd7);
                checkOutput($sformatf("err.illegal%0d", t), 64'(illegal), 64'd1);
                checkOutput($sformatf("err.enables%0d", t),
                    64'({memRead, memWrite, irWrite, pcWrite, regWr, link, instr_done,
                         aluSrc, regDst, memToReg, li}), 64'd0);
            end
        end
        checkOutput("err.countHeld", 64'(instr_count), 64'(expCount));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("err.clearedIllegal", 64'(illegal), 64'd0);
        checkOutput("err.clearedState", 64'(state), 64'd0);
        checkOutput("err.clearedCount", 64'(instr_count), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
